// File: rtl/jedro_1_rf_pkg.sv
// Shared definitions for the register-file writeback controller.
//   RF_DATA_WIDTH      default register data width
//   RF_REG_ADDR_WIDTH  default register address width
//   RF_NUM_REGISTERS   number of architectural registers (x0-x31)
//   wb_src_e           identifies a writeback requester (used for round-robin state)
package jedro_1_rf_pkg;

  localparam int unsigned RF_DATA_WIDTH     = 32;
  localparam int unsigned RF_REG_ADDR_WIDTH = 5;
  localparam int unsigned RF_NUM_REGISTERS  = 2 ** RF_REG_ADDR_WIDTH;

  typedef enum logic {
    WB_ALU = 1'b0,
    WB_LSU = 1'b1
  } wb_src_e;

endpackage

// File: rtl/jedro_1_rf_scoreboard.sv
// Pending-write scoreboard for the integer register file.
//   clk_i, rstn_i        clock, asynchronous active-low reset
//   issue_valid_i        decode wants to issue
//   issue_rs1_i/rs2_i    source registers of the issuing instruction
//   issue_rd_i           destination register (0 = no writeback)
//   clr_valid_i          a writeback was accepted this cycle
//   clr_addr_i           destination register of that writeback
//   issue_stall_o        issue blocked by a RAW/WAW hazard
//   pending_o            one bit per register with an outstanding write (bit 0 always 0)
module jedro_1_rf_scoreboard
  import jedro_1_rf_pkg::*;
#(
  parameter int unsigned REG_ADDR_WIDTH = RF_REG_ADDR_WIDTH
) (
  input  logic                           clk_i,
  input  logic                           rstn_i,
  input  logic                           issue_valid_i,
  input  logic [REG_ADDR_WIDTH-1:0]      issue_rs1_i,
  input  logic [REG_ADDR_WIDTH-1:0]      issue_rs2_i,
  input  logic [REG_ADDR_WIDTH-1:0]      issue_rd_i,
  input  logic                           clr_valid_i,
  input  logic [REG_ADDR_WIDTH-1:0]      clr_addr_i,
  output logic                           issue_stall_o,
  output logic [2**REG_ADDR_WIDTH-1:0]   pending_o
);

  localparam int unsigned NumRegs = 2 ** REG_ADDR_WIDTH;

  logic [NumRegs-1:0] pending_q, pending_d;
  logic               issue_fire;

  // Hazard check uses only the registered vector: a clear in this cycle is not bypassed.
  always_comb begin
    issue_stall_o = issue_valid_i &
                    (pending_q[issue_rs1_i] | pending_q[issue_rs2_i] | pending_q[issue_rd_i]);
  end

  assign issue_fire = issue_valid_i & ~issue_stall_o & (issue_rd_i != '0);

  always_comb begin
    pending_d = pending_q;
    if (clr_valid_i) begin
      pending_d[clr_addr_i] = 1'b0;
    end
    // Applied after the clear so a same-cycle set on the same register wins.
    if (issue_fire) begin
      pending_d[issue_rd_i] = 1'b1;
    end
    pending_d[0] = 1'b0;
  end

  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      pending_q <= '0;
    end else begin
      pending_q <= pending_d;
    end
  end

  assign pending_o = pending_q;

endmodule

// File: rtl/jedro_1_rf_wb_ctrl.sv
// Register-file write port C controller.
// Round-robin arbitration between ALU and LSU writeback, a registered write port,
// and a pending-write scoreboard for decode hazard stalls.
//   clk_i, rstn_i                  clock, asynchronous active-low reset
//   alu_valid_i/addr_i/data_i      ALU writeback request; alu_ready_o = accepted
//   lsu_valid_i/addr_i/data_i      LSU writeback request; lsu_ready_o = accepted
//   issue_valid_i, issue_rs1_i,
//   issue_rs2_i, issue_rd_i        decode issue request
//   issue_stall_o                  issue blocked by hazard
//   pending_o                      scoreboard vector
//   wpc_addr_o/data_o/we_o         register file write port (one cycle after accept)
module jedro_1_rf_wb_ctrl
  import jedro_1_rf_pkg::*;
#(
  parameter int unsigned DATA_WIDTH     = RF_DATA_WIDTH,
  parameter int unsigned REG_ADDR_WIDTH = RF_REG_ADDR_WIDTH
) (
  input  logic                           clk_i,
  input  logic                           rstn_i,
  input  logic                           alu_valid_i,
  output logic                           alu_ready_o,
  input  logic [REG_ADDR_WIDTH-1:0]      alu_addr_i,
  input  logic [DATA_WIDTH-1:0]          alu_data_i,
  input  logic                           lsu_valid_i,
  output logic                           lsu_ready_o,
  input  logic [REG_ADDR_WIDTH-1:0]      lsu_addr_i,
  input  logic [DATA_WIDTH-1:0]          lsu_data_i,
  input  logic                           issue_valid_i,
  input  logic [REG_ADDR_WIDTH-1:0]      issue_rs1_i,
  input  logic [REG_ADDR_WIDTH-1:0]      issue_rs2_i,
  input  logic [REG_ADDR_WIDTH-1:0]      issue_rd_i,
  output logic                           issue_stall_o,
  output logic [2**REG_ADDR_WIDTH-1:0]   pending_o,
  output logic [REG_ADDR_WIDTH-1:0]      wpc_addr_o,
  output logic [DATA_WIDTH-1:0]          wpc_data_o,
  output logic                           wpc_we_o
);

  wb_src_e                   last_grant_q, last_grant_d;
  logic                      grant_alu, grant_lsu;
  logic                      wb_accept;
  logic [REG_ADDR_WIDTH-1:0] wb_addr;
  logic [DATA_WIDTH-1:0]     wb_data;

  logic                      we_q, we_d;
  logic [REG_ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [DATA_WIDTH-1:0]     data_q, data_d;

  // Round robin: on a tie the requester that did not win last time is granted.
  always_comb begin
    grant_alu = alu_valid_i & (~lsu_valid_i | (last_grant_q == WB_LSU));
    grant_lsu = lsu_valid_i & (~alu_valid_i | (last_grant_q == WB_ALU));
  end

  // Readies are masked while in reset: the write-port flops cannot capture then,
  // so signalling acceptance would silently drop the write.
  assign alu_ready_o = rstn_i & grant_alu;
  assign lsu_ready_o = rstn_i & grant_lsu;
  assign wb_accept   = alu_ready_o | lsu_ready_o;

  always_comb begin
    wb_addr = alu_ready_o ? alu_addr_i : lsu_addr_i;
    wb_data = alu_ready_o ? alu_data_i : lsu_data_i;
  end

  always_comb begin
    last_grant_d = last_grant_q;
    we_d         = 1'b0;
    addr_d       = addr_q;
    data_d       = data_q;
    if (wb_accept) begin
      last_grant_d = alu_ready_o ? WB_ALU : WB_LSU;
      // x0 writes are accepted and consume a grant but never reach the register file.
      we_d         = (wb_addr != '0);
      addr_d       = wb_addr;
      data_d       = wb_data;
    end
  end

  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      last_grant_q <= WB_LSU;
      we_q         <= 1'b0;
      addr_q       <= '0;
      data_q       <= '0;
    end else begin
      last_grant_q <= last_grant_d;
      we_q         <= we_d;
      addr_q       <= addr_d;
      data_q       <= data_d;
    end
  end

  assign wpc_we_o   = we_q;
  assign wpc_addr_o = addr_q;
  assign wpc_data_o = data_q;

  jedro_1_rf_scoreboard #(
    .REG_ADDR_WIDTH (REG_ADDR_WIDTH)
  ) u_scoreboard (
    .clk_i         (clk_i),
    .rstn_i        (rstn_i),
    .issue_valid_i (issue_valid_i),
    .issue_rs1_i   (issue_rs1_i),
    .issue_rs2_i   (issue_rs2_i),
    .issue_rd_i    (issue_rd_i),
    .clr_valid_i   (wb_accept),
    .clr_addr_i    (wb_addr),
    .issue_stall_o (issue_stall_o),
    .pending_o     (pending_o)
  );

endmodule

// File: tb/tb_jedro_1_rf_wb_ctrl.sv
// Directed, table-driven bench for jedro_1_rf_wb_ctrl.
module tb_jedro_1_rf_wb_ctrl;

  logic        clk;
  logic        rstn;
  logic        alu_valid, alu_ready;
  logic [4:0]  alu_addr;
  logic [31:0] alu_data;
  logic        lsu_valid, lsu_ready;
  logic [4:0]  lsu_addr;
  logic [31:0] lsu_data;
  logic        issue_valid, issue_stall;
  logic [4:0]  issue_rs1, issue_rs2, issue_rd;
  logic [31:0] pending;
  logic [4:0]  wpc_addr;
  logic [31:0] wpc_data;
  logic        wpc_we;

  int n_vec;
  int miscompares;

  jedro_1_rf_wb_ctrl #(
    .DATA_WIDTH     (32),
    .REG_ADDR_WIDTH (5)
  ) dut (
    .clk_i         (clk),
    .rstn_i        (rstn),
    .alu_valid_i   (alu_valid),
    .alu_ready_o   (alu_ready),
    .alu_addr_i    (alu_addr),
    .alu_data_i    (alu_data),
    .lsu_valid_i   (lsu_valid),
    .lsu_ready_o   (lsu_ready),
    .lsu_addr_i    (lsu_addr),
    .lsu_data_i    (lsu_data),
    .issue_valid_i (issue_valid),
    .issue_rs1_i   (issue_rs1),
    .issue_rs2_i   (issue_rs2),
    .issue_rd_i    (issue_rd),
    .issue_stall_o (issue_stall),
    .pending_o     (pending),
    .wpc_addr_o    (wpc_addr),
    .wpc_data_o    (wpc_data),
    .wpc_we_o      (wpc_we)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        av;
    logic [4:0]  aa;
    logic [31:0] ad;
    logic        lv;
    logic [4:0]  la;
    logic [31:0] ld;
    logic        iv;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [4:0]  rd;
    logic        e_ar;    // same-cycle expectations
    logic        e_lr;
    logic        e_st;
    logic        e_we;    // expectations after the clock edge
    logic [4:0]  e_addr;
    logic [31:0] e_data;
    logic [31:0] e_pend;
  } vec_t;

  localparam int NumVec = 20;
  vec_t vecs [NumVec];

  task automatic chk(input string name, input int idx, input logic [31:0] act,
                     input logic [31:0] exp);
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s vec %0d: got %h expected %h", name, idx, act, exp);
    end
  endtask

  task automatic apply(input int i);
    @(negedge clk);
    alu_valid   = vecs[i].av;  alu_addr  = vecs[i].aa;  alu_data = vecs[i].ad;
    lsu_valid   = vecs[i].lv;  lsu_addr  = vecs[i].la;  lsu_data = vecs[i].ld;
    issue_valid = vecs[i].iv;  issue_rs1 = vecs[i].rs1; issue_rs2 = vecs[i].rs2;
    issue_rd    = vecs[i].rd;
    #1;
    chk("alu_ready", i, {31'd0, alu_ready}, {31'd0, vecs[i].e_ar});
    chk("lsu_ready", i, {31'd0, lsu_ready}, {31'd0, vecs[i].e_lr});
    chk("issue_stall", i, {31'd0, issue_stall}, {31'd0, vecs[i].e_st});
    @(posedge clk);
    #1;
    chk("wpc_we", i, {31'd0, wpc_we}, {31'd0, vecs[i].e_we});
    chk("wpc_addr", i, {27'd0, wpc_addr}, {27'd0, vecs[i].e_addr});
    chk("wpc_data", i, wpc_data, vecs[i].e_data);
    chk("pending", i, pending, vecs[i].e_pend);
    n_vec++;
  endtask

  initial begin
    n_vec       = 0;
    miscompares = 0;

    //          av  aa     ad            lv  la     ld            iv  rs1   rs2   rd
    //          ar  lr  st  we  addr   data          pend
    // Reset released with both requesters pending: ALU wins the first tie.
    vecs[0]  = '{1'b1, 5'd3, 32'h1111_0003, 1'b1, 5'd4, 32'h2222_0004, 1'b0, 5'd0, 5'd0, 5'd0,
                 1'b1, 1'b0, 1'b0, 1'b1, 5'd3, 32'h1111_0003, 32'h0};
    vecs[1]  = '{1'b0, 5'd3, 32'h1111_0003, 1'b1, 5'd4, 32'h2222_0004, 1'b0, 5'd0, 5'd0, 5'd0,
                 1'b0, 1'b1, 1'b0, 1'b1, 5'd4, 32'h2222_0004, 32'h0};
    // Both valid for four cycles: grants alternate, losers hold their request.
    vecs[2]  = '{1'b1, 5'd5, 32'hA000_0005, 1'b1, 5'd6, 32'hB000_0006, 1'b0, 5'd0, 5'd0, 5'd0,
                 1'b1, 1'b0, 1'b0, 1'b1, 5'd5, 32'hA000_0005, 32'h0};
    vecs[3]  = '{1'b1, 5'd5, 32'hA100_0005, 1'b1, 5'd6, 32'hB000_0006, 1'b0, 5'd0, 5'd0, 5'd0,
                 1'b0, 1'b1, 1'b0, 1'b1, 5'd6, 32'hB000_0006, 32'h0};
    vecs[4]  = '{1'b1, 5'd5, 32'hA100_0005, 1'b1, 5'd6, 32'hB100_0006, 1'b0, 5'd0, 5'd0, 5'd0,
                 1'b1, 1'b0, 1'b0, 1'b1, 5'd5, 32'hA100_0005, 32'h0};
    vecs[5]  = '{1'b1, 5'd5, 32'hA200_0005, 1'b1, 5'd6, 32'hB100_0006, 1'b0, 5'd0, 5'd0, 5'd0,
                 1'b0, 1'b1, 1'b0, 1'b1, 5'd6, 32'hB100_0006, 32'h0};
    vecs[6]  = '{1'b1, 5'd5, 32'hA200_0005, 1'b0, 5'd6, 32'hB100_0006, 1'b0, 5'd0, 5'd0, 5'd0,
                 1'b1, 1'b0, 1'b0, 1'b1, 5'd5, 32'hA200_0005, 32'h0};
    // LSU write to x0: accepted, no write enable, moves last grant to LSU.
    vecs[7]  = '{1'b0, 5'd0, 32'h0,         1'b1, 5'd0, 32'hDEAD_BEEF, 1'b0, 5'd0, 5'd0, 5'd0,
                 1'b0, 1'b1, 1'b0, 1'b0, 5'd0, 32'hDEAD_BEEF, 32'h0};
    vecs[8]  = '{1'b1, 5'd2, 32'h0000_0202, 1'b1, 5'd10, 32'h0000_030A, 1'b0, 5'd0, 5'd0, 5'd0,
                 1'b1, 1'b0, 1'b0, 1'b1, 5'd2, 32'h0000_0202, 32'h0};
    vecs[9]  = '{1'b0, 5'd2, 32'h0000_0202, 1'b1, 5'd10, 32'h0000_030A, 1'b0, 5'd0, 5'd0, 5'd0,
                 1'b0, 1'b1, 1'b0, 1'b1, 5'd10, 32'h0000_030A, 32'h0};
    // Idle: write enable drops, address/data hold.
    vecs[10] = '{1'b0, 5'd0, 32'h0,         1'b0, 5'd0, 32'h0,         1'b0, 5'd0, 5'd0, 5'd0,
                 1'b0, 1'b0, 1'b0, 1'b0, 5'd10, 32'h0000_030A, 32'h0};
    // RAW on x7: stall until the cycle after the ALU writeback is accepted.
    vecs[11] = '{1'b0, 5'd0, 32'h0,         1'b0, 5'd0, 32'h0,         1'b1, 5'd0, 5'd0, 5'd7,
                 1'b0, 1'b0, 1'b0, 1'b0, 5'd10, 32'h0000_030A, 32'h0000_0080};
    vecs[12] = '{1'b0, 5'd0, 32'h0,         1'b0, 5'd0, 32'h0,         1'b1, 5'd7, 5'd0, 5'd0,
                 1'b0, 1'b0, 1'b1, 1'b0, 5'd10, 32'h0000_030A, 32'h0000_0080};
    vecs[13] = '{1'b1, 5'd7, 32'h0000_0777, 1'b0, 5'd0, 32'h0,         1'b1, 5'd7, 5'd0, 5'd0,
                 1'b1, 1'b0, 1'b1, 1'b1, 5'd7, 32'h0000_0777, 32'h0};
    vecs[14] = '{1'b0, 5'd0, 32'h0,         1'b0, 5'd0, 32'h0,         1'b1, 5'd7, 5'd0, 5'd0,
                 1'b0, 1'b0, 1'b0, 1'b0, 5'd7, 32'h0000_0777, 32'h0};
    // Same-cycle set and clear of x9: set wins.
    vecs[15] = '{1'b0, 5'd0, 32'h0,         1'b1, 5'd9, 32'h0000_0999, 1'b1, 5'd0, 5'd0, 5'd9,
                 1'b0, 1'b1, 1'b0, 1'b1, 5'd9, 32'h0000_0999, 32'h0000_0200};
    // Stalled issue (rs2 hazard) must not set rd=12.
    vecs[16] = '{1'b0, 5'd0, 32'h0,         1'b0, 5'd0, 32'h0,         1'b1, 5'd0, 5'd9, 5'd12,
                 1'b0, 1'b0, 1'b1, 1'b0, 5'd9, 32'h0000_0999, 32'h0000_0200};
    // WAW hazard on x9.
    vecs[17] = '{1'b0, 5'd0, 32'h0,         1'b0, 5'd0, 32'h0,         1'b1, 5'd0, 5'd0, 5'd9,
                 1'b0, 1'b0, 1'b1, 1'b0, 5'd9, 32'h0000_0999, 32'h0000_0200};
    vecs[18] = '{1'b0, 5'd0, 32'h0,         1'b1, 5'd9, 32'h0000_09A9, 1'b0, 5'd0, 5'd0, 5'd0,
                 1'b0, 1'b1, 1'b0, 1'b1, 5'd9, 32'h0000_09A9, 32'h0};
    // x0 operands/destination never stall and never set pending.
    vecs[19] = '{1'b0, 5'd0, 32'h0,         1'b0, 5'd0, 32'h0,         1'b1, 5'd0, 5'd0, 5'd0,
                 1'b0, 1'b0, 1'b0, 1'b0, 5'd9, 32'h0000_09A9, 32'h0};

    // Reset held with both requesters asserting: every output stays 0.
    rstn        = 1'b0;
    alu_valid   = 1'b1; alu_addr = 5'd3; alu_data = 32'h1111_0003;
    lsu_valid   = 1'b1; lsu_addr = 5'd4; lsu_data = 32'h2222_0004;
    issue_valid = 1'b0; issue_rs1 = 5'd0; issue_rs2 = 5'd0; issue_rd = 5'd0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_we", -1, {31'd0, wpc_we}, 32'd0);
    chk("rst_addr", -1, {27'd0, wpc_addr}, 32'd0);
    chk("rst_data", -1, wpc_data, 32'd0);
    chk("rst_pending", -1, pending, 32'd0);
    chk("rst_alu_ready", -1, {31'd0, alu_ready}, 32'd0);
    chk("rst_lsu_ready", -1, {31'd0, lsu_ready}, 32'd0);
    chk("rst_stall", -1, {31'd0, issue_stall}, 32'd0);
    n_vec++;
    rstn = 1'b1;

    for (int i = 0; i < NumVec; i++) begin
      apply(i);
    end

    // Asynchronous reset with x7 pending and a write in flight.
    @(negedge clk);
    alu_valid   = 1'b1; alu_addr = 5'd3; alu_data = 32'h0000_0033;
    lsu_valid   = 1'b0;
    issue_valid = 1'b1; issue_rs1 = 5'd0; issue_rs2 = 5'd0; issue_rd = 5'd7;
    @(posedge clk);
    #1;
    alu_valid   = 1'b0;
    issue_valid = 1'b0;
    chk("pre_async_pending", 100, pending, 32'h0000_0080);
    chk("pre_async_we", 100, {31'd0, wpc_we}, 32'd1);
    chk("pre_async_addr", 100, {27'd0, wpc_addr}, 32'd3);
    #1;
    rstn = 1'b0;
    #1;
    chk("async_pending", 101, pending, 32'd0);
    chk("async_we", 101, {31'd0, wpc_we}, 32'd0);
    chk("async_addr", 101, {27'd0, wpc_addr}, 32'd0);
    chk("async_data", 101, wpc_data, 32'd0);
    n_vec++;

    // After release the round-robin state is back to favouring the ALU.
    @(posedge clk);
    #1;
    rstn = 1'b1;
    alu_valid = 1'b1; alu_addr = 5'd1;
    lsu_valid = 1'b1; lsu_addr = 5'd2;
    #1;
    chk("post_rst_alu_ready", 102, {31'd0, alu_ready}, 32'd1);
    chk("post_rst_lsu_ready", 102, {31'd0, lsu_ready}, 32'd0);
    n_vec++;

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, miscompares);
    $finish;
  end

endmodule
